// File: rtl/bullet_launcher_pkg.sv
// Shared types and helpers for the bullet launcher: FSM states, signed
// trajectory coordinates, screen bounds and trajectory arithmetic.
package bullet_pkg;

  typedef enum logic [1:0] {
    B_IDLE     = 2'd0,
    B_FLIGHT   = 2'd1,
    B_COOLDOWN = 2'd2
  } b_state_e;

  // 12 bits holds SPEED(<=4) * any 10-bit signed step and any on-screen position
  typedef logic signed [11:0] coord_t;

  localparam int         X_MAX_DEF      = 639;
  localparam int         Y_MAX_DEF      = 479;
  localparam logic [7:0] FIRE_KEY_DEF   = 8'h2C;
  localparam logic [7:0] RELOAD_KEY_DEF = 8'h15;

  function automatic coord_t scale_motion(input logic [9:0] step, input coord_t mult);
    coord_t ext;
    ext = {{2{step[9]}}, step};
    return ext * mult;
  endfunction

  function automatic logic out_of_bounds(input coord_t nx, input coord_t ny,
                                         input coord_t x_max, input coord_t y_max);
    return (nx < 12'sd0) || (nx > x_max) || (ny < 12'sd0) || (ny > y_max);
  endfunction

endpackage

// File: rtl/bullet_launcher_key_edge_detect.sv
// Keycode history register and press-edge detection for the fire and reload
// keys; a held key produces a single edge.
module key_edge_detect
  import bullet_pkg::*;
#(
  parameter logic [7:0] FIRE_KEY   = FIRE_KEY_DEF,
  parameter logic [7:0] RELOAD_KEY = RELOAD_KEY_DEF
) (
  input  logic       clk2,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       fire_edge,
  output logic       reload_edge
);

  logic [7:0] key_prev_q;

  // keycode history, one cycle behind
  always_ff @(posedge clk2) begin
    if (!Reset) begin
      key_prev_q <= 8'h00;
    end else begin
      key_prev_q <= keycode;
    end
  end

  assign fire_edge   = (keycode == FIRE_KEY)   && (key_prev_q != FIRE_KEY);
  assign reload_edge = (keycode == RELOAD_KEY) && (key_prev_q != RELOAD_KEY);

endmodule

// File: rtl/bullet_launcher.sv
// Single-bullet launcher: fires on a key press, flies a latched trajectory
// once per frame until off-screen or hit, then enforces a cooldown.
module bullet_launcher
  import bullet_pkg::*;
#(
  parameter logic [7:0] FIRE_KEY        = FIRE_KEY_DEF,
  parameter logic [7:0] RELOAD_KEY      = RELOAD_KEY_DEF,
  parameter int         SPEED           = 2,
  parameter int         X_MAX           = X_MAX_DEF,
  parameter int         Y_MAX           = Y_MAX_DEF,
  parameter int         COOLDOWN_FRAMES = 15,
  parameter int         AMMO            = 9
) (
  input  logic       clk2,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic [9:0] motion_x,
  input  logic [9:0] motion_y,
  input  logic [9:0] spawn_x,
  input  logic [9:0] spawn_y,
  input  logic       hit,
  output logic       bullet_active,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic       shot_fired,
  output logic [3:0] ammo_left,
  output logic       busy
);

  localparam coord_t     SPEED_C = coord_t'(SPEED);
  localparam coord_t     XMAX_C  = coord_t'(X_MAX);
  localparam coord_t     YMAX_C  = coord_t'(Y_MAX);
  localparam logic [7:0] CD_C    = 8'(COOLDOWN_FRAMES);
  localparam logic [3:0] AMMO_C  = 4'(AMMO);

  b_state_e   state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  coord_t     vx_q, vx_d, vy_q, vy_d;
  logic [3:0] ammo_q, ammo_d;
  logic [7:0] cd_q, cd_d;
  logic       active_q, active_d;
  logic       shot_q, shot_d;
  logic       busy_q, busy_d;

  logic   fire_edge_s, reload_edge_s;
  coord_t nx_s, ny_s;
  logic   end_flight_s;

  key_edge_detect #(
    .FIRE_KEY  (FIRE_KEY),
    .RELOAD_KEY(RELOAD_KEY)
  ) u_keys (
    .clk2       (clk2),
    .Reset      (Reset),
    .keycode    (keycode),
    .fire_edge  (fire_edge_s),
    .reload_edge(reload_edge_s)
  );

  assign nx_s = coord_t'({2'b00, x_q}) + vx_q;
  assign ny_s = coord_t'({2'b00, y_q}) + vy_q;
  // a hit wins over movement in the same cycle
  assign end_flight_s = hit || (frame_tick && out_of_bounds(nx_s, ny_s, XMAX_C, YMAX_C));

  // state and datapath registers
  always_ff @(posedge clk2) begin
    if (!Reset) begin
      state_q  <= B_IDLE;
      x_q      <= 10'd0;
      y_q      <= 10'd0;
      vx_q     <= 12'sd0;
      vy_q     <= 12'sd0;
      ammo_q   <= AMMO_C;
      cd_q     <= 8'd0;
      active_q <= 1'b0;
      shot_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      ammo_q   <= ammo_d;
      cd_q     <= cd_d;
      active_q <= active_d;
      shot_q   <= shot_d;
      busy_q   <= busy_d;
    end
  end

  // next-state and datapath update
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    ammo_d   = ammo_q;
    cd_d     = cd_q;
    active_d = active_q;
    shot_d   = 1'b0;

    case (state_q)
      B_IDLE: begin
        if (fire_edge_s && (ammo_q != 4'd0)) begin
          state_d  = B_FLIGHT;
          x_d      = spawn_x;
          y_d      = spawn_y;
          vx_d     = scale_motion(motion_x, SPEED_C);
          vy_d     = scale_motion(motion_y, SPEED_C);
          active_d = 1'b1;
          shot_d   = 1'b1;
          ammo_d   = ammo_q - 4'd1;
        end else if (reload_edge_s) begin
          ammo_d = AMMO_C;
        end else begin
          state_d = B_IDLE;
        end
      end
      B_FLIGHT: begin
        if (end_flight_s) begin
          active_d = 1'b0;
          if (CD_C == 8'd0) begin
            state_d = B_IDLE;
          end else begin
            state_d = B_COOLDOWN;
            cd_d    = CD_C;
          end
        end else if (frame_tick) begin
          x_d = nx_s[9:0];
          y_d = ny_s[9:0];
        end else begin
          state_d = B_FLIGHT;
        end
      end
      B_COOLDOWN: begin
        if (frame_tick) begin
          // a zero count here can only come from corruption; leave rather than wrap
          if (cd_q <= 8'd1) begin
            state_d = B_IDLE;
            cd_d    = 8'd0;
          end else begin
            cd_d = cd_q - 8'd1;
          end
        end else begin
          state_d = B_COOLDOWN;
        end
      end
      default: begin
        state_d  = B_IDLE;
        active_d = 1'b0;
        cd_d     = 8'd0;
      end
    endcase

    busy_d = (state_d != B_IDLE);
  end

  assign bullet_active = active_q;
  assign bullet_x      = x_q;
  assign bullet_y      = y_q;
  assign shot_fired    = shot_q;
  assign ammo_left     = ammo_q;
  assign busy          = busy_q;

endmodule
